// File: rtl/voltage_monitor.sv
// Windowed voltage statistics (mean/min/max over 2**WINDOW_LOG2 samples)
// plus a debounced over/under-voltage alarm FSM.
module voltage_monitor #(
    parameter int unsigned WINDOW_LOG2 = 3,
    parameter int unsigned ALARM_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [7:0] data_in,
    input  logic [7:0] thr_hi,
    input  logic [7:0] thr_lo,
    input  logic       clear,
    output logic [7:0] avg_out,
    output logic [7:0] min_out,
    output logic [7:0] max_out,
    output logic       stats_valid,
    output logic       alarm_hi,
    output logic       alarm_lo
);

    localparam int unsigned AW = 8 + WINDOW_LOG2;
    localparam logic [3:0]  AC = 4'(ALARM_COUNT);

    typedef enum logic [2:0] {
        NORMAL,
        PEND_HI,
        ALARM_HI,
        PEND_LO,
        ALARM_LO
    } state_e;

    logic [AW-1:0]          acc_q, acc_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [7:0]             wmin_q, wmin_d, wmax_q, wmax_d;
    logic [7:0]             avg_q, avg_d, min_q, min_d, max_q, max_d;
    logic                   sv_q, sv_d;
    state_e                 state_q, state_d;
    logic [3:0]             run_q, run_d;

    logic [AW-1:0] sum;
    logic [AW-1:0] sum_shr;
    logic [7:0]    smin, smax;
    logic          hi, lo;
    logic [3:0]    run_inc;
    state_e        nrm_state;
    logic [3:0]    nrm_run;

    always_comb begin
        sum     = acc_q + AW'(data_in);
        sum_shr = sum >> WINDOW_LOG2;
        smin    = (data_in < wmin_q) ? data_in : wmin_q;
        smax    = (data_in > wmax_q) ? data_in : wmax_q;
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        wmin_d = wmin_q;
        wmax_d = wmax_q;
        avg_d  = avg_q;
        min_d  = min_q;
        max_d  = max_q;
        sv_d   = 1'b0;
        if (clear) begin
            acc_d  = '0;
            cnt_d  = '0;
            wmin_d = '1;
            wmax_d = '0;
        end else if (sample_en) begin
            if (cnt_q == '1) begin
                // Final sample of the window: publish and restart in one step
                avg_d  = sum_shr[7:0];
                min_d  = smin;
                max_d  = smax;
                sv_d   = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
                wmin_d = '1;
                wmax_d = '0;
            end else begin
                acc_d  = sum;
                cnt_d  = cnt_q + WINDOW_LOG2'(1);
                wmin_d = smin;
                wmax_d = smax;
            end
        end
    end

    always_comb begin
        hi      = data_in > thr_hi;
        lo      = data_in < thr_lo;
        run_inc = run_q + 4'd1;

        // Entry decision from NORMAL; high wins when both thresholds trip
        nrm_state = NORMAL;
        nrm_run   = '0;
        if (hi) begin
            nrm_state = (AC == 4'd1) ? ALARM_HI : PEND_HI;
            nrm_run   = (AC == 4'd1) ? 4'd0 : 4'd1;
        end else if (lo) begin
            nrm_state = (AC == 4'd1) ? ALARM_LO : PEND_LO;
            nrm_run   = (AC == 4'd1) ? 4'd0 : 4'd1;
        end

        state_d = state_q;
        run_d   = run_q;
        if (clear) begin
            state_d = NORMAL;
            run_d   = '0;
        end else if (sample_en) begin
            case (state_q)
                NORMAL: begin
                    state_d = nrm_state;
                    run_d   = nrm_run;
                end
                PEND_HI: begin
                    if (hi) begin
                        if (run_inc == AC) begin
                            state_d = ALARM_HI;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = nrm_state;
                        run_d   = nrm_run;
                    end
                end
                PEND_LO: begin
                    if (lo && !hi) begin
                        if (run_inc == AC) begin
                            state_d = ALARM_LO;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = nrm_state;
                        run_d   = nrm_run;
                    end
                end
                ALARM_HI: begin
                    if (!hi) begin
                        if (run_inc == AC) begin
                            state_d = NORMAL;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ALARM_LO: begin
                    if (!lo) begin
                        if (run_inc == AC) begin
                            state_d = NORMAL;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            wmin_q  <= '1;
            wmax_q  <= '0;
            avg_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            sv_q    <= 1'b0;
            state_q <= NORMAL;
            run_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            wmin_q  <= wmin_d;
            wmax_q  <= wmax_d;
            avg_q   <= avg_d;
            min_q   <= min_d;
            max_q   <= max_d;
            sv_q    <= sv_d;
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign avg_out     = avg_q;
    assign min_out     = min_q;
    assign max_out     = max_q;
    assign stats_valid = sv_q;
    assign alarm_hi    = (state_q == ALARM_HI);
    assign alarm_lo    = (state_q == ALARM_LO);

endmodule

// File: tb/tb_voltage_monitor.sv
// Directed bench for voltage_monitor: window statistics, alarm FSM, clear and reset.
module tb_voltage_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic       clear;
    logic [7:0] data_in;
    logic [7:0] thr_hi;
    logic [7:0] thr_lo;
    logic [7:0] avg_out;
    logic [7:0] min_out;
    logic [7:0] max_out;
    logic       stats_valid;
    logic       alarm_hi;
    logic       alarm_lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    voltage_monitor #(
        .WINDOW_LOG2(3),
        .ALARM_COUNT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .data_in    (data_in),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .clear      (clear),
        .avg_out    (avg_out),
        .min_out    (min_out),
        .max_out    (max_out),
        .stats_valid(stats_valid),
        .alarm_hi   (alarm_hi),
        .alarm_lo   (alarm_lo)
    );

    // Inputs change on the falling edge; results of the previous rising edge are visible afterwards
    task automatic drive(input logic en, input logic [7:0] d, input logic clr);
        @(negedge clk);
        sample_en = en;
        data_in   = d;
        clear     = clr;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0; data_in = '0;
        thr_hi = 8'hFF; thr_lo = 8'h00;
        #3;
        total_cnt++;
        if ({avg_out, min_out, max_out, stats_valid, alarm_hi, alarm_lo} !== 27'd0)
            $display("FAIL reset_outputs: got %h expected 0", {avg_out, min_out, max_out, stats_valid, alarm_hi, alarm_lo});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if ({avg_out, min_out, max_out, stats_valid, alarm_hi, alarm_lo} !== 27'd0)
            $display("FAIL post_release_outputs: got %h expected 0", {avg_out, min_out, max_out, stats_valid, alarm_hi, alarm_lo});
        else pass_cnt++;
    endtask

    task automatic test_avg_basic;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(10 + i), 1'b0);
            if (i == 7) begin
                total_cnt++;
                if (stats_valid !== 1'b0) $display("FAIL basic_sv_early: got %b expected 0", stats_valid);
                else pass_cnt++;
            end
        end
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if (stats_valid !== 1'b1) $display("FAIL basic_sv: got %b expected 1", stats_valid);
        else pass_cnt++;
        total_cnt++;
        if (avg_out !== 8'd13) $display("FAIL basic_avg: got %0d expected 13", avg_out);
        else pass_cnt++;
        total_cnt++;
        if (min_out !== 8'd10) $display("FAIL basic_min: got %0d expected 10", min_out);
        else pass_cnt++;
        total_cnt++;
        if (max_out !== 8'd17) $display("FAIL basic_max: got %0d expected 17", max_out);
        else pass_cnt++;
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if (stats_valid !== 1'b0) $display("FAIL basic_sv_pulse: got %b expected 0", stats_valid);
        else pass_cnt++;
        total_cnt++;
        if (avg_out !== 8'd13) $display("FAIL basic_avg_hold: got %0d expected 13", avg_out);
        else pass_cnt++;
    endtask

    task automatic test_gapped_ff;
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive((i % 2) == 0, 8'hFF, 1'b0);
            if (stats_valid === 1'b1) pulses++;
        end
        repeat (3) begin
            drive(1'b0, 8'd0, 1'b0);
            if (stats_valid === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses != 1) $display("FAIL gapped_pulses: got %0d expected 1", pulses);
        else pass_cnt++;
        total_cnt++;
        if ({avg_out, min_out, max_out} !== 24'hFFFFFF)
            $display("FAIL gapped_stats: got %h expected ffffff", {avg_out, min_out, max_out});
        else pass_cnt++;
    endtask

    task automatic test_alarm_hi;
        logic [7:0] seq [8];
        seq = '{8'd201, 8'd201, 8'd201, 8'd150, 8'd201, 8'd201, 8'd201, 8'd201};
        thr_hi = 8'd200; thr_lo = 8'd0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, seq[i], 1'b0);
            total_cnt++;
            if (alarm_hi !== 1'b0) $display("FAIL alarm_hi_early: got %b expected 0 at step %0d", alarm_hi, i);
            else pass_cnt++;
        end
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if (alarm_hi !== 1'b1) $display("FAIL alarm_hi_rise: got %b expected 1", alarm_hi);
        else pass_cnt++;
        total_cnt++;
        if ({stats_valid, avg_out, min_out, max_out} !== {1'b1, 8'd194, 8'd150, 8'd201})
            $display("FAIL alarm_hi_window: got sv=%b avg=%0d min=%0d max=%0d expected 1/194/150/201",
                     stats_valid, avg_out, min_out, max_out);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd180, 1'b0);
            total_cnt++;
            if (alarm_hi !== 1'b1) $display("FAIL alarm_hi_hold: got %b expected 1 at step %0d", alarm_hi, i);
            else pass_cnt++;
        end
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if (alarm_hi !== 1'b0) $display("FAIL alarm_hi_fall: got %b expected 0", alarm_hi);
        else pass_cnt++;
    endtask

    task automatic test_alarm_lo_clear;
        thr_lo = 8'd50; thr_hi = 8'd200;
        drive(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'd40, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if ({alarm_lo, alarm_hi} !== 2'b10) $display("FAIL alarm_lo_rise: got lo=%b hi=%b expected lo=1 hi=0", alarm_lo, alarm_hi);
        else pass_cnt++;
        drive(1'b1, 8'd40, 1'b1);
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if (alarm_lo !== 1'b0) $display("FAIL clear_alarm_lo: got %b expected 0", alarm_lo);
        else pass_cnt++;
        total_cnt++;
        if (stats_valid !== 1'b0) $display("FAIL clear_no_sv: got %b expected 0", stats_valid);
        else pass_cnt++;
        total_cnt++;
        if ({avg_out, min_out, max_out} !== {8'd194, 8'd150, 8'd201})
            $display("FAIL clear_retain: got avg=%0d min=%0d max=%0d expected 194/150/201", avg_out, min_out, max_out);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'd60, 1'b0);
            if (i == 7) begin
                total_cnt++;
                if (stats_valid !== 1'b0) $display("FAIL clear_discard: got sv=%b expected 0", stats_valid);
                else pass_cnt++;
            end
        end
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if ({stats_valid, avg_out, min_out, max_out, alarm_lo} !== {1'b1, 8'd60, 8'd60, 8'd60, 1'b0})
            $display("FAIL post_clear_window: got sv=%b avg=%0d min=%0d max=%0d lo=%b expected 1/60/60/60/0",
                     stats_valid, avg_out, min_out, max_out, alarm_lo);
        else pass_cnt++;
    endtask

    task automatic test_priority;
        thr_hi = 8'd50; thr_lo = 8'd100;
        drive(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'd75, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if ({alarm_hi, alarm_lo} !== 2'b10) $display("FAIL priority_hi: got hi=%b lo=%b expected hi=1 lo=0", alarm_hi, alarm_lo);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'd75, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if ({stats_valid, avg_out, alarm_hi} !== {1'b1, 8'd75, 1'b1})
            $display("FAIL priority_window: got sv=%b avg=%0d hi=%b expected 1/75/1", stats_valid, avg_out, alarm_hi);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) drive(1'b1, 8'd75, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if ({alarm_hi, avg_out} !== {1'b1, 8'd75}) $display("FAIL pre_reset_state: got hi=%b avg=%0d expected 1/75", alarm_hi, avg_out);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({avg_out, min_out, max_out, stats_valid, alarm_hi, alarm_lo} !== 27'd0)
            $display("FAIL async_reset: got %h expected 0", {avg_out, min_out, max_out, stats_valid, alarm_hi, alarm_lo});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1; thr_hi = 8'hFF; thr_lo = 8'h00;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'd100, 1'b0);
            if (i == 3 || i == 7) begin
                total_cnt++;
                if (stats_valid !== 1'b0) $display("FAIL reset_partial_discard: got sv=%b expected 0 at step %0d", stats_valid, i);
                else pass_cnt++;
            end
        end
        drive(1'b0, 8'd0, 1'b0);
        total_cnt++;
        if ({stats_valid, avg_out, min_out, max_out, alarm_hi} !== {1'b1, 8'd100, 8'd100, 8'd100, 1'b0})
            $display("FAIL post_reset_window: got sv=%b avg=%0d min=%0d max=%0d hi=%b expected 1/100/100/100/0",
                     stats_valid, avg_out, min_out, max_out, alarm_hi);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int w;
        for (int i = 0; i <= 24; i++) begin
            drive(i < 24, 8'(i), 1'b0);
            if (i >= 1) begin
                total_cnt++;
                if (stats_valid !== (((i - 1) % 8) == 7))
                    $display("FAIL b2b_sv: got %b expected %b at sample %0d", stats_valid, ((i - 1) % 8) == 7, i - 1);
                else pass_cnt++;
                if (((i - 1) % 8) == 7) begin
                    w = (i - 1) / 8;
                    total_cnt++;
                    if ({avg_out, min_out, max_out} !== {8'(8 * w + 3), 8'(8 * w), 8'(8 * w + 7)})
                        $display("FAIL b2b_stats: got avg=%0d min=%0d max=%0d expected %0d/%0d/%0d window %0d",
                                 avg_out, min_out, max_out, 8 * w + 3, 8 * w, 8 * w + 7, w);
                    else pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_avg_basic();
        test_gapped_ff();
        test_alarm_hi();
        test_alarm_lo_clear();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
